// File: rtl/decode_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_pkg: RV32I opcode constants, immediate formats and decode helpers |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package decode_pkg;

  localparam logic [6:0] c_opc_load     = 7'b0000011;
  localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
  localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_auipc    = 7'b0010111;
  localparam logic [6:0] c_opc_store    = 7'b0100011;
  localparam logic [6:0] c_opc_op       = 7'b0110011;
  localparam logic [6:0] c_opc_lui      = 7'b0110111;
  localparam logic [6:0] c_opc_branch   = 7'b1100011;
  localparam logic [6:0] c_opc_jalr     = 7'b1100111;
  localparam logic [6:0] c_opc_jal      = 7'b1101111;
  localparam logic [6:0] c_opc_system   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_format(input logic [6:0] opc);
    case (opc)
      c_opc_load, c_opc_op_imm, c_opc_jalr, c_opc_system: return FMT_I;
      c_opc_store:            return FMT_S;
      c_opc_branch:           return FMT_B;
      c_opc_lui, c_opc_auipc: return FMT_U;
      c_opc_jal:              return FMT_J;
      default:                return FMT_NONE;
    endcase
  endfunction

  function automatic logic is_rv32i(input logic [6:0] opc);
    case (opc)
      c_opc_load, c_opc_misc_mem, c_opc_op_imm, c_opc_auipc, c_opc_store,
      c_opc_op, c_opc_lui, c_opc_branch, c_opc_jalr, c_opc_jal,
      c_opc_system: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  // Immediate sign-extended to 32 bits; U-format is already shifted left by 12.
  function automatic logic signed [31:0] build_imm(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{ins[31]}}, ins[31:20]};
      FMT_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   return {ins[31:12], 12'b0};
      FMT_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_regfile: x0-hardwired register file, 2 async reads, 1 sync write  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decode_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  input  logic [4:0]            read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  localparam int c_idx_w = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  // Out-of-range indices (RV32E) read as zero and are never written.
  function automatic logic live_index(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < REG_COUNT);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (write && live_index(write_reg)) begin
      r_regs[write_reg[c_idx_w-1:0]] <= write_data;
    end
  end

  assign read_data_a = live_index(read_reg_a) ? r_regs[read_reg_a[c_idx_w-1:0]] : '0;
  assign read_data_b = live_index(read_reg_b) ? r_regs[read_reg_b[c_idx_w-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/decode_stage_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_stage_unit: registered RV32I decode stage with bypass and stall   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decode_stage_unit
  import decode_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_PC,
  input  logic [31:0]             in_instruction,
  input  logic                    write,
  input  logic [4:0]              write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [6:0]              opcode,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic [4:0]              rd,
  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  output logic [DATA_WIDTH-1:0]   extend_imm,
  output logic [ADDRESS_BITS-1:0] branch_target,
  output logic [ADDRESS_BITS-1:0] JAL_target,
  output logic                    illegal,
  input  logic                    report
);

  logic [6:0]             w_opc;
  logic [4:0]             w_rs1;
  logic [4:0]             w_rs2;
  logic [4:0]             w_rd;
  imm_fmt_e               w_fmt;
  logic signed [31:0]     w_imm;
  logic signed [31:0]     w_b_imm;
  logic signed [31:0]     w_j_imm;
  logic [DATA_WIDTH-1:0]  w_rf_a;
  logic [DATA_WIDTH-1:0]  w_rf_b;
  logic [DATA_WIDTH-1:0]  w_rs1_val;
  logic [DATA_WIDTH-1:0]  w_rs2_val;
  logic                   w_hazard;
  logic                   w_accept;
  logic                   w_is_op;
  logic                   w_use_rd;
  logic                   w_use_rs1;
  logic                   w_use_rs2;
  logic                   w_illegal;
  logic [31:0]            r_cycle;

  assign w_opc   = in_instruction[6:0];
  assign w_rd    = in_instruction[11:7];
  assign w_rs1   = in_instruction[19:15];
  assign w_rs2   = in_instruction[24:20];
  assign w_fmt   = imm_format(w_opc);
  assign w_imm   = build_imm(in_instruction, w_fmt);
  assign w_b_imm = build_imm(in_instruction, FMT_B);
  assign w_j_imm = build_imm(in_instruction, FMT_J);

  decode_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clock       (clock),
    .reset       (reset),
    .write       (write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg_a  (w_rs1),
    .read_data_a (w_rf_a),
    .read_reg_b  (w_rs2),
    .read_data_b (w_rf_b)
  );

  assign w_rs1_val = (write && write_reg == w_rs1 && w_rs1 != 5'd0) ? write_data : w_rf_a;
  assign w_rs2_val = (write && write_reg == w_rs2 && w_rs2 != 5'd0) ? write_data : w_rf_b;

  // A held load whose destination feeds the incoming instruction blocks it;
  // the cycle after the load leaves therefore carries no instruction.
  assign w_hazard = out_valid && (opcode == c_opc_load) && (rd != 5'd0) &&
                    ((rd == w_rs1) || (rd == w_rs2));
  assign in_ready = (!out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

  assign w_is_op   = (w_opc == c_opc_op);
  assign w_use_rd  = w_is_op || (w_fmt inside {FMT_I, FMT_U, FMT_J});
  assign w_use_rs1 = w_is_op || (w_fmt inside {FMT_I, FMT_S, FMT_B});
  assign w_use_rs2 = w_is_op || (w_fmt inside {FMT_S, FMT_B});
  assign w_illegal = !is_rv32i(w_opc) ||
                     (w_use_rd  && int'(w_rd)  >= REG_COUNT) ||
                     (w_use_rs1 && int'(w_rs1) >= REG_COUNT) ||
                     (w_use_rs2 && int'(w_rs2) >= REG_COUNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_PC        <= '0;
      opcode        <= '0;
      funct3        <= '0;
      funct7        <= '0;
      rs1           <= '0;
      rs2           <= '0;
      rd            <= '0;
      rs1_data      <= '0;
      rs2_data      <= '0;
      extend_imm    <= '0;
      branch_target <= '0;
      JAL_target    <= '0;
      illegal       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid     <= 1'b1;
      out_PC        <= in_PC;
      opcode        <= w_opc;
      funct3        <= in_instruction[14:12];
      funct7        <= in_instruction[31:25];
      rs1           <= w_rs1;
      rs2           <= w_rs2;
      rd            <= w_rd;
      rs1_data      <= w_rs1_val;
      rs2_data      <= w_rs2_val;
      extend_imm    <= DATA_WIDTH'(w_imm);
      branch_target <= in_PC + ADDRESS_BITS'(w_b_imm);
      JAL_target    <= in_PC + ADDRESS_BITS'(w_j_imm);
      illegal       <= w_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Held operands track writeback so they are current when released.
      if (write && write_reg == rs1 && rs1 != 5'd0) rs1_data <= write_data;
      if (write && write_reg == rs2 && rs2 != 5'd0) rs2_data <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && report && out_valid && out_ready)
      $display("CORE %0d cycle %0d PC %h inst %h rs1 x%0d=%h rs2 x%0d=%h rd x%0d imm %h",
               CORE, r_cycle, out_PC, {funct7, rs2, rs1, funct3, rd, opcode},
               rs1, rs1_data, rs2, rs2_data, rd, extend_imm);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_stage_unit: directed stimulus with queue-based scoreboard      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_decode_stage_unit;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_PC = '0;
  logic [31:0] in_instruction = '0;
  logic        write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic        out_ready = 1'b1;
  logic        report = 1'b1;

  logic        in_ready, out_valid, illegal;
  logic [19:0] out_PC, branch_target, JAL_target;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, extend_imm;

  logic        e_in_ready, e_out_valid, e_illegal;
  logic [19:0] e_out_PC, e_branch_target, e_JAL_target;
  logic [6:0]  e_opcode, e_funct7;
  logic [2:0]  e_funct3;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [31:0] e_rs1_data, e_rs2_data, e_extend_imm;

  decode_stage_unit dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_PC(in_PC), .in_instruction(in_instruction), .write(write), .write_reg(write_reg),
    .write_data(write_data), .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .extend_imm(extend_imm),
    .branch_target(branch_target), .JAL_target(JAL_target), .illegal(illegal), .report(report)
  );

  decode_stage_unit #(.CORE(1), .REG_COUNT(16)) dut_e (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_PC(in_PC), .in_instruction(in_instruction), .write(write), .write_reg(write_reg),
    .write_data(write_data), .out_valid(e_out_valid), .out_ready(out_ready), .out_PC(e_out_PC),
    .opcode(e_opcode), .funct3(e_funct3), .funct7(e_funct7), .rs1(e_rs1), .rs2(e_rs2), .rd(e_rd),
    .rs1_data(e_rs1_data), .rs2_data(e_rs2_data), .extend_imm(e_extend_imm),
    .branch_target(e_branch_target), .JAL_target(e_JAL_target), .illegal(e_illegal), .report(1'b0)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, opc, rd, d1, d2, imm, bt, jt, ill;
    bit chk_data, chk_bt, chk_jt;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every output transfer must match the oldest expectation.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got PC %h want no transfer", out_PC);
      end else begin
        m = sbq.pop_front();
        chk("sb_pc", {12'b0, out_PC}, m.pc);
        chk("sb_opcode", {25'b0, opcode}, m.opc);
        chk("sb_rd", {27'b0, rd}, m.rd);
        chk("sb_imm", extend_imm, m.imm);
        chk("sb_illegal", {31'b0, illegal}, m.ill);
        if (m.chk_data) begin
          chk("sb_rs1_data", rs1_data, m.d1);
          chk("sb_rs2_data", rs2_data, m.d2);
        end
        if (m.chk_bt) chk("sb_branch_target", {12'b0, branch_target}, m.bt);
        if (m.chk_jt) chk("sb_jal_target", {12'b0, JAL_target}, m.jt);
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] pc, opc, rd, d1, d2, imm, ill, input bit cd);
    exp_t e;
    e.pc = pc; e.opc = opc; e.rd = rd; e.d1 = d1; e.d2 = d2; e.imm = imm; e.ill = ill;
    e.bt = '0; e.jt = '0; e.chk_data = cd; e.chk_bt = 0; e.chk_jt = 0;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
    return {7'b0, s2, s1, 3'b000, d, OP_REG};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2, input logic [4:0] s1);
    return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2, input logic [4:0] s1);
    return {imm[12], imm[10:5], s2, s1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    write = 1'b1; write_reg = r; write_data = d;
    tick(1);
    write = 1'b0;
  endtask

  // Presents one instruction until accepted (bounded); returns stall count and
  // whether the stage was occupied in the accepting cycle.
  task automatic issue(input logic [19:0] pc, input logic [31:0] ins, input bit push,
                       input exp_t e, output int stalls, output logic ov);
    bit acc = 0;
    stalls = 0;
    ov = 1'b0;
    in_PC = pc; in_instruction = ins; in_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1;
        ov = out_valid;
        if (push) sbq.push_back(e);
      end else stalls++;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got no accept want accept PC %h", pc);
    end
  endtask

  initial begin
    exp_t e;
    int st;
    logic ov;

    tick(2);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_out_pc", {12'b0, out_PC}, 0);
    reset = 1'b1;
    tick(1);

    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd5, 32'h1234);

    issue(20'h100, enc_i(12'hFFF, 5'd5, 3'd0, 5'd6, OP_IMM), 1,
          mk(32'h100, 32'h13, 6, 32'h1234, 0, 32'hFFFF_FFFF, 0, 1), st, ov);
    chk("addi_latency_valid", {31'b0, out_valid}, 1);

    e = mk(32'h200, 32'h63, 25, 32'h11, 32'h22, 32'hFFFF_FFF8, 0, 1);
    e.bt = 32'h1F8; e.chk_bt = 1;
    issue(20'h200, enc_b(13'h1FF8, 5'd2, 5'd1), 1, e, st, ov);

    e = mk(32'h10, 32'h6F, 1, 0, 0, 32'h800, 0, 0);
    e.jt = 32'h810; e.chk_jt = 1;
    issue(20'h010, enc_j(21'h000800, 5'd1), 1, e, st, ov);

    issue(20'h020, {20'h12345, 5'd3, OP_LUI}, 1, mk(32'h20, 32'h37, 3, 0, 0, 32'h1234_5000, 0, 0), st, ov);
    issue(20'h024, enc_s(12'hFFC, 5'd2, 5'd1), 1, mk(32'h24, 32'h23, 28, 32'h11, 32'h22, 32'hFFFF_FFFC, 0, 1), st, ov);
    issue(20'h028, 32'h0000_007F, 1, mk(32'h28, 32'h7F, 0, 0, 0, 0, 1, 1), st, ov);

    // Load-use: LW x7 then ADD x8,x7,x1.
    issue(20'h030, enc_i(12'h0, 5'd1, 3'd2, 5'd7, OP_LD), 1, mk(32'h30, 32'h03, 7, 32'h11, 0, 0, 0, 1), st, ov);
    issue(20'h034, enc_r(5'd1, 5'd7, 5'd8), 1, mk(32'h34, 32'h33, 8, 0, 32'h11, 0, 0, 1), st, ov);
    chk("load_use_stalls", st, 1);
    chk("load_use_bubble", {31'b0, ov}, 0);
    tick(1);

    // Held operand refresh.
    out_ready = 1'b0;
    issue(20'h040, enc_i(12'h001, 5'd5, 3'd0, 5'd9, OP_IMM), 1, mk(32'h40, 32'h13, 9, 32'hBEEF, 32'h11, 1, 0, 1), st, ov);
    chk("hold_in_ready", {31'b0, in_ready}, 0);
    wr(5'd5, 32'hBEEF);
    chk("hold_refresh_rs1", rs1_data, 32'hBEEF);
    out_ready = 1'b1;
    tick(1);

    // Same-cycle write and accept.
    write = 1'b1; write_reg = 5'd5; write_data = 32'hCAFE;
    issue(20'h044, enc_i(12'h000, 5'd5, 3'd0, 5'd10, OP_IMM), 1, mk(32'h44, 32'h13, 10, 32'hCAFE, 0, 0, 0, 1), st, ov);
    write = 1'b0;
    tick(1);

    // Flush during a stall, with a writeback in the flush cycle.
    out_ready = 1'b0;
    issue(20'h050, enc_i(12'h0, 5'd1, 3'd2, 5'd7, OP_LD), 0, e, st, ov);
    in_PC = 20'h054; in_instruction = enc_r(5'd1, 5'd7, 5'd8); in_valid = 1'b1;
    flush = 1'b1; write = 1'b1; write_reg = 5'd11; write_data = 32'h5555;
    @(negedge clock);
    chk("flush_stall_in_ready", {31'b0, in_ready}, 0);
    @(posedge clock);
    #1;
    flush = 1'b0; write = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 0);

    // Instruction accepted in the flush cycle is dropped.
    out_ready = 1'b1;
    in_PC = 20'h058; in_instruction = 32'h0000_0013; in_valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    chk("flush_accept_in_ready", {31'b0, in_ready}, 1);
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_out_valid", {31'b0, out_valid}, 0);

    issue(20'h060, enc_r(5'd0, 5'd11, 5'd12), 1, mk(32'h60, 32'h33, 12, 32'h5555, 0, 0, 0, 1), st, ov);

    // RV32E instance flags x20; the full-width instance does not.
    issue(20'h064, enc_r(5'd2, 5'd1, 5'd20), 1, mk(32'h64, 32'h33, 20, 32'h11, 32'h22, 0, 0, 1), st, ov);
    chk("rv32e_valid", {31'b0, e_out_valid}, 1);
    chk("rv32e_illegal_x20", {31'b0, e_illegal}, 1);
    issue(20'h068, enc_r(5'd2, 5'd1, 5'd3), 1, mk(32'h68, 32'h33, 3, 32'h11, 32'h22, 0, 0, 1), st, ov);
    chk("rv32e_legal_x3", {31'b0, e_illegal}, 0);
    tick(1);

    // Asynchronous reset in the middle of a load-use stall.
    out_ready = 1'b0;
    issue(20'h070, enc_i(12'h0, 5'd1, 3'd2, 5'd7, OP_LD), 0, e, st, ov);
    in_PC = 20'h074; in_instruction = enc_r(5'd1, 5'd7, 5'd8); in_valid = 1'b1;
    @(negedge clock);
    chk("rst_stall_in_ready", {31'b0, in_ready}, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 0);
    chk("async_rst_out_pc", {12'b0, out_PC}, 0);
    chk("async_rst_opcode", {25'b0, opcode}, 0);
    chk("async_rst_rs1_data", rs1_data, 0);
    chk("async_rst_imm", extend_imm, 0);
    chk("async_rst_btgt", {12'b0, branch_target}, 0);
    in_valid = 1'b0;
    tick(2);
    reset = 1'b1;
    out_ready = 1'b1;
    issue(20'h300, 32'h0000_0013, 1, mk(32'h300, 32'h13, 0, 0, 0, 0, 0, 1), st, ov);
    chk("post_rst_stalls", st, 0);
    chk("post_rst_valid", {31'b0, out_valid}, 1);
    issue(20'h304, enc_i(12'h000, 5'd5, 3'd0, 5'd13, OP_IMM), 1, mk(32'h304, 32'h13, 13, 0, 0, 0, 0, 1), st, ov);
    tick(3);

    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
